// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: one loader write port and two read ports (CPU, debug)
// sharing a single registered-read memory through an IDLE/ISSUE/CAPTURE/RESP sequence.
module imem_arbiter (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LdReq,
    input  logic [31:0] LdAddr,
    input  logic [31:0] LdData,
    input  logic [1:0]  LdSize,
    input  logic        CpuReq,
    input  logic [31:0] CpuAddr,
    input  logic [1:0]  CpuSize,
    input  logic        DbgReq,
    input  logic [31:0] DbgAddr,
    input  logic [1:0]  DbgSize,
    input  logic [31:0] MemReadData,
    output logic [31:0] MemWriteData,
    output logic [31:0] MemWriteAddr,
    output logic [31:0] MemReadAddr,
    output logic [1:0]  MemWIM,
    output logic [1:0]  MemRIM,
    output logic        LdGnt,
    output logic        CpuGnt,
    output logic        DbgGnt,
    output logic        LdDone,
    output logic        CpuValid,
    output logic [31:0] CpuData,
    output logic        DbgValid,
    output logic [31:0] DbgData,
    output logic        Err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    typedef enum logic [1:0] {SRC_LD, SRC_CPU, SRC_DBG} src_t;

    state_t      state, state_next;
    src_t        src, src_next;
    logic        reject, reject_next;
    logic        pref_dbg, pref_dbg_next;

    logic        pick_ld, pick_cpu, pick_dbg;
    src_t        req_src;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [2:0]  req_count;
    logic [32:0] req_last;
    logic        req_reject;

    logic [31:0] mem_write_data_next, mem_write_addr_next, mem_read_addr_next;
    logic [1:0]  mem_wim_next, mem_rim_next;
    logic        ld_gnt_next, cpu_gnt_next, dbg_gnt_next;
    logic        ld_done_next, cpu_valid_next, dbg_valid_next, err_next;
    logic [31:0] cpu_data_next, dbg_data_next;

    // Loader always wins; the two readers alternate when both are waiting.
    // The last-byte address is formed in 33 bits so a top-of-space address cannot wrap into range.
    always_comb begin
        pick_ld  = LdReq;
        pick_cpu = !LdReq && CpuReq && (!DbgReq || !pref_dbg);
        pick_dbg = !LdReq && DbgReq && !pick_cpu;

        req_src  = SRC_LD;
        req_addr = LdAddr;
        req_size = LdSize;
        if (pick_cpu) begin
            req_src  = SRC_CPU;
            req_addr = CpuAddr;
            req_size = CpuSize;
        end else if (pick_dbg) begin
            req_src  = SRC_DBG;
            req_addr = DbgAddr;
            req_size = DbgSize;
        end

        case (req_size)
            2'd1:    req_count = 3'd1;
            2'd2:    req_count = 3'd2;
            2'd3:    req_count = 3'd4;
            default: req_count = 3'd0;
        endcase

        req_last   = {1'b0, req_addr} + {30'd0, req_count} - 33'd1;
        req_reject = (req_size == 2'd0) || (req_last > 33'h0_0000_FFFF);
    end

    // Next-state and next-output logic; every output is registered, so memory
    // strobes for ISSUE are prepared on the grant edge.
    always_comb begin
        state_next          = state;
        src_next            = src;
        reject_next         = reject;
        pref_dbg_next       = pref_dbg;
        mem_write_data_next = 32'd0;
        mem_write_addr_next = 32'd0;
        mem_read_addr_next  = 32'd0;
        mem_wim_next        = 2'd0;
        mem_rim_next        = 2'd0;
        ld_gnt_next         = 1'b0;
        cpu_gnt_next        = 1'b0;
        dbg_gnt_next        = 1'b0;
        ld_done_next        = 1'b0;
        cpu_valid_next      = 1'b0;
        dbg_valid_next      = 1'b0;
        err_next            = 1'b0;
        cpu_data_next       = CpuData;
        dbg_data_next       = DbgData;

        case (state)
            IDLE: begin
                if (pick_ld || pick_cpu || pick_dbg) begin
                    state_next   = ISSUE;
                    src_next     = req_src;
                    reject_next  = req_reject;
                    ld_gnt_next  = pick_ld;
                    cpu_gnt_next = pick_cpu;
                    dbg_gnt_next = pick_dbg;
                    if (!pick_ld) begin
                        pref_dbg_next = pick_cpu;
                    end
                    if (!req_reject) begin
                        if (pick_ld) begin
                            mem_wim_next        = req_size;
                            mem_write_addr_next = req_addr;
                            mem_write_data_next = LdData;
                        end else begin
                            mem_rim_next       = req_size;
                            mem_read_addr_next = req_addr;
                        end
                    end
                end
            end
            ISSUE: begin
                if (src == SRC_LD || reject) begin
                    state_next     = RESP;
                    err_next       = reject;
                    ld_done_next   = (src == SRC_LD);
                    cpu_valid_next = (src == SRC_CPU);
                    dbg_valid_next = (src == SRC_DBG);
                    if (src == SRC_CPU) begin
                        cpu_data_next = 32'd0;
                    end
                    if (src == SRC_DBG) begin
                        dbg_data_next = 32'd0;
                    end
                end else begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = RESP;
                if (src == SRC_DBG) begin
                    dbg_valid_next = 1'b1;
                    dbg_data_next  = MemReadData;
                end else begin
                    cpu_valid_next = 1'b1;
                    cpu_data_next  = MemReadData;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            src          <= SRC_LD;
            reject       <= 1'b0;
            pref_dbg     <= 1'b0;
            MemWriteData <= 32'd0;
            MemWriteAddr <= 32'd0;
            MemReadAddr  <= 32'd0;
            MemWIM       <= 2'd0;
            MemRIM       <= 2'd0;
            LdGnt        <= 1'b0;
            CpuGnt       <= 1'b0;
            DbgGnt       <= 1'b0;
            LdDone       <= 1'b0;
            CpuValid     <= 1'b0;
            DbgValid     <= 1'b0;
            Err          <= 1'b0;
            CpuData      <= 32'd0;
            DbgData      <= 32'd0;
        end else begin
            state        <= state_next;
            src          <= src_next;
            reject       <= reject_next;
            pref_dbg     <= pref_dbg_next;
            MemWriteData <= mem_write_data_next;
            MemWriteAddr <= mem_write_addr_next;
            MemReadAddr  <= mem_read_addr_next;
            MemWIM       <= mem_wim_next;
            MemRIM       <= mem_rim_next;
            LdGnt        <= ld_gnt_next;
            CpuGnt       <= cpu_gnt_next;
            DbgGnt       <= dbg_gnt_next;
            LdDone       <= ld_done_next;
            CpuValid     <= cpu_valid_next;
            DbgValid     <= dbg_valid_next;
            Err          <= err_next;
            CpuData      <= cpu_data_next;
            DbgData      <= dbg_data_next;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a byte-addressed memory model, a table of
// single-requester transactions, and hand sequences for arbitration and mid-transaction reset.
module tb_imem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        LdReq = 1'b0, CpuReq = 1'b0, DbgReq = 1'b0;
    logic [31:0] LdAddr = '0, LdData = '0, CpuAddr = '0, DbgAddr = '0;
    logic [1:0]  LdSize = '0, CpuSize = '0, DbgSize = '0;
    logic [31:0] MemReadData = '0;
    logic [31:0] MemWriteData, MemWriteAddr, MemReadAddr, CpuData, DbgData;
    logic [1:0]  MemWIM, MemRIM;
    logic        LdGnt, CpuGnt, DbgGnt, LdDone, CpuValid, DbgValid, Err;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] cpu_model = '0;
    logic [31:0] dbg_model = '0;

    logic [7:0] mem [0:65535];

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam logic [1:0] WHO_LD = 2'd0, WHO_CPU = 2'd1, WHO_DBG = 2'd2;

    imem_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .LdReq(LdReq), .LdAddr(LdAddr), .LdData(LdData), .LdSize(LdSize),
        .CpuReq(CpuReq), .CpuAddr(CpuAddr), .CpuSize(CpuSize),
        .DbgReq(DbgReq), .DbgAddr(DbgAddr), .DbgSize(DbgSize),
        .MemReadData(MemReadData),
        .MemWriteData(MemWriteData), .MemWriteAddr(MemWriteAddr), .MemReadAddr(MemReadAddr),
        .MemWIM(MemWIM), .MemRIM(MemRIM),
        .LdGnt(LdGnt), .CpuGnt(CpuGnt), .DbgGnt(DbgGnt),
        .LdDone(LdDone), .CpuValid(CpuValid), .CpuData(CpuData),
        .DbgValid(DbgValid), .DbgData(DbgData), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Little-endian byte memory with registered read data.
    always @(posedge Clk) begin
        if (MemWIM != 2'd0) begin
            mem[MemWriteAddr[15:0]] <= MemWriteData[7:0];
            if (MemWIM >= 2'd2) mem[MemWriteAddr[15:0] + 16'd1] <= MemWriteData[15:8];
            if (MemWIM == 2'd3) begin
                mem[MemWriteAddr[15:0] + 16'd2] <= MemWriteData[23:16];
                mem[MemWriteAddr[15:0] + 16'd3] <= MemWriteData[31:24];
            end
        end
        if (MemRIM != 2'd0) begin
            case (MemRIM)
                2'd1:    MemReadData <= {24'd0, mem[MemReadAddr[15:0]]};
                2'd2:    MemReadData <= {16'd0, mem[MemReadAddr[15:0] + 16'd1], mem[MemReadAddr[15:0]]};
                default: MemReadData <= {mem[MemReadAddr[15:0] + 16'd3], mem[MemReadAddr[15:0] + 16'd2],
                                         mem[MemReadAddr[15:0] + 16'd1], mem[MemReadAddr[15:0]]};
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ctl"}, {21'd0, LdGnt, CpuGnt, DbgGnt, LdDone, CpuValid, DbgValid, Err, MemWIM, MemRIM}, 32'd0);
        checkOutput({tag, ".wdata"}, MemWriteData, 32'd0);
        checkOutput({tag, ".waddr"}, MemWriteAddr, 32'd0);
        checkOutput({tag, ".raddr"}, MemReadAddr, 32'd0);
        checkOutput({tag, ".cpudata"}, CpuData, 32'd0);
        checkOutput({tag, ".dbgdata"}, DbgData, 32'd0);
    endtask

    task automatic doReset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        cpu_model = '0;
        dbg_model = '0;
    endtask

    // One single-requester transaction, started from IDLE one step after a clock edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        int gcyc = -1, dcyc = -1, gnt_n = 0, rim_n = 0, wim_n = 0, err_n = 0;
        logic gnt, done, got_err = 1'bx, rd_ok;
        logic [31:0] got_data = 'x, rim_addr = '0, wim_addr = '0, wim_data = '0;
        logic [1:0] rim_sz = '0, wim_sz = '0;
        rd_ok = (v.who != WHO_LD) && !v.exp_err;
        case (v.who)
            WHO_LD:  begin LdAddr = v.addr; LdData = v.data; LdSize = v.size; LdReq = 1'b1; end
            WHO_CPU: begin CpuAddr = v.addr; CpuSize = v.size; CpuReq = 1'b1; end
            default: begin DbgAddr = v.addr; DbgSize = v.size; DbgReq = 1'b1; end
        endcase
        for (int cyc = 1; cyc <= 12 && dcyc < 0; cyc++) begin
            @(posedge Clk); #1;
            gnt  = (v.who == WHO_LD) ? LdGnt  : (v.who == WHO_CPU) ? CpuGnt   : DbgGnt;
            done = (v.who == WHO_LD) ? LdDone : (v.who == WHO_CPU) ? CpuValid : DbgValid;
            if (gnt) begin
                gnt_n++;
                if (gcyc < 0) gcyc = cyc;
                LdReq = 1'b0; CpuReq = 1'b0; DbgReq = 1'b0;
            end
            if (MemRIM != 2'd0) begin rim_n++; rim_addr = MemReadAddr; rim_sz = MemRIM; end
            if (MemWIM != 2'd0) begin wim_n++; wim_addr = MemWriteAddr; wim_data = MemWriteData; wim_sz = MemWIM; end
            if (Err) err_n++;
            if (done) begin
                dcyc = cyc;
                got_err = Err;
                got_data = (v.who == WHO_CPU) ? CpuData : DbgData;
            end
        end
        LdReq = 1'b0; CpuReq = 1'b0; DbgReq = 1'b0;
        @(posedge Clk); #1;

        checkOutput({tag, ".gnt_cycle"}, gcyc, 32'd1);
        checkOutput({tag, ".gnt_count"}, gnt_n, 32'd1);
        checkOutput({tag, ".done_cycle"}, dcyc, gcyc + (rd_ok ? 2 : 1));
        checkOutput({tag, ".err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        checkOutput({tag, ".err_pulses"}, err_n, {31'd0, v.exp_err});
        checkOutput({tag, ".rim_pulses"}, rim_n, {31'd0, rd_ok});
        checkOutput({tag, ".wim_pulses"}, wim_n, {31'd0, (v.who == WHO_LD) && !v.exp_err});
        if (rim_n == 1) begin
            checkOutput({tag, ".rim_addr"}, rim_addr, v.addr);
            checkOutput({tag, ".rim_size"}, {30'd0, rim_sz}, {30'd0, v.size});
        end
        if (wim_n == 1) begin
            checkOutput({tag, ".wim_addr"}, wim_addr, v.addr);
            checkOutput({tag, ".wim_data"}, wim_data, v.data);
            checkOutput({tag, ".wim_size"}, {30'd0, wim_sz}, {30'd0, v.size});
        end
        if (v.who == WHO_CPU) begin
            checkOutput({tag, ".data"}, got_data, v.exp_data);
            cpu_model = v.exp_data;
        end else if (v.who == WHO_DBG) begin
            checkOutput({tag, ".data"}, got_data, v.exp_data);
            dbg_model = v.exp_data;
        end
        checkOutput({tag, ".cpu_hold"}, CpuData, cpu_model);
        checkOutput({tag, ".dbg_hold"}, DbgData, dbg_model);
    endtask

    initial begin
        vec_t vecs [20];
        logic [1:0] order [4];
        int n;
        int valid_n, err_n;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        vecs[0]  = '{WHO_LD,  32'h0000_0005, 32'h9BB5_67CA, 2'd3, 32'h0000_0000, 1'b0};
        vecs[1]  = '{WHO_CPU, 32'h0000_0005, 32'h0,         2'd3, 32'h9BB5_67CA, 1'b0};
        vecs[2]  = '{WHO_DBG, 32'h0000_0005, 32'h0,         2'd1, 32'h0000_00CA, 1'b0};
        vecs[3]  = '{WHO_DBG, 32'h0000_0006, 32'h0,         2'd2, 32'h0000_B567, 1'b0};
        vecs[4]  = '{WHO_LD,  32'h0000_FFFC, 32'h1122_3344, 2'd3, 32'h0000_0000, 1'b0};
        vecs[5]  = '{WHO_CPU, 32'h0000_FFFC, 32'h0,         2'd3, 32'h1122_3344, 1'b0};
        vecs[6]  = '{WHO_CPU, 32'h0000_FFFE, 32'h0,         2'd3, 32'h0000_0000, 1'b1};
        vecs[7]  = '{WHO_DBG, 32'h0000_FFFF, 32'h0,         2'd1, 32'h0000_0011, 1'b0};
        vecs[8]  = '{WHO_DBG, 32'h0000_FFFF, 32'h0,         2'd2, 32'h0000_0000, 1'b1};
        vecs[9]  = '{WHO_CPU, 32'h0000_0000, 32'h0,         2'd0, 32'h0000_0000, 1'b1};
        vecs[10] = '{WHO_LD,  32'h0000_FFFF, 32'hA5A5_A5A5, 2'd3, 32'h0000_0000, 1'b1};
        vecs[11] = '{WHO_DBG, 32'h0000_FFFC, 32'h0,         2'd3, 32'h1122_3344, 1'b0};
        vecs[12] = '{WHO_LD,  32'h0000_0100, 32'hDEAD_BEEF, 2'd1, 32'h0000_0000, 1'b0};
        vecs[13] = '{WHO_CPU, 32'h0000_0100, 32'h0,         2'd3, 32'h0000_00EF, 1'b0};
        vecs[14] = '{WHO_LD,  32'hFFFF_FFFF, 32'h0000_0077, 2'd1, 32'h0000_0000, 1'b1};
        vecs[15] = '{WHO_CPU, 32'hFFFF_FFFE, 32'h0,         2'd3, 32'h0000_0000, 1'b1};
        vecs[16] = '{WHO_CPU, 32'h0000_0004, 32'h0,         2'd3, 32'hB567_CA00, 1'b0};
        vecs[17] = '{WHO_LD,  32'h0000_FFFE, 32'hCAFE_F00D, 2'd2, 32'h0000_0000, 1'b0};
        vecs[18] = '{WHO_DBG, 32'h0000_FFFC, 32'h0,         2'd3, 32'hF00D_3344, 1'b0};
        vecs[19] = '{WHO_DBG, 32'h0001_0000, 32'h0,         2'd1, 32'h0000_0000, 1'b1};

        // Asynchronous reset before any clock edge.
        #2 Rst = 1'b1;
        #1 checkAllZero("reset");
        @(posedge Clk);
        #1 Rst = 1'b0;

        for (int i = 0; i < 20; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Both readers held from reset: grants must alternate starting with the CPU.
        CpuAddr = 32'h0; CpuSize = 2'd1; DbgAddr = 32'h0; DbgSize = 2'd1;
        CpuReq = 1'b1; DbgReq = 1'b1;
        doReset();
        for (int i = 0; i < 4; i++) order[i] = 2'd3;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge Clk); #1;
            if (CpuGnt && DbgGnt) checkOutput("rr.both_gnt", 32'd1, 32'd0);
            else if (CpuGnt) begin order[n] = WHO_CPU; n++; end
            else if (DbgGnt) begin order[n] = WHO_DBG; n++; end
        end
        CpuReq = 1'b0; DbgReq = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        checkOutput("rr.g0", {30'd0, order[0]}, {30'd0, WHO_CPU});
        checkOutput("rr.g1", {30'd0, order[1]}, {30'd0, WHO_DBG});
        checkOutput("rr.g2", {30'd0, order[2]}, {30'd0, WHO_CPU});
        checkOutput("rr.g3", {30'd0, order[3]}, {30'd0, WHO_DBG});

        // Three simultaneous requests: loader first, then CPU, then debug.
        doReset();
        LdAddr = 32'h200; LdData = 32'h1234_5678; LdSize = 2'd3;
        CpuAddr = 32'h200; CpuSize = 2'd3; DbgAddr = 32'h200; DbgSize = 2'd1;
        LdReq = 1'b1; CpuReq = 1'b1; DbgReq = 1'b1;
        for (int i = 0; i < 3; i++) order[i] = 2'd3;
        n = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge Clk); #1;
            if (n < 3 && LdGnt) begin order[n] = WHO_LD; n++; LdReq = 1'b0; end
            if (n < 3 && CpuGnt) begin order[n] = WHO_CPU; n++; CpuReq = 1'b0; end
            if (n < 3 && DbgGnt) begin order[n] = WHO_DBG; n++; DbgReq = 1'b0; end
        end
        LdReq = 1'b0; CpuReq = 1'b0; DbgReq = 1'b0;
        checkOutput("prio.g0", {30'd0, order[0]}, {30'd0, WHO_LD});
        checkOutput("prio.g1", {30'd0, order[1]}, {30'd0, WHO_CPU});
        checkOutput("prio.g2", {30'd0, order[2]}, {30'd0, WHO_DBG});
        checkOutput("prio.cpudata", CpuData, 32'h1234_5678);
        checkOutput("prio.dbgdata", DbgData, 32'h0000_0078);

        // Reset during CAPTURE of a CPU read aborts it without a response.
        CpuAddr = 32'h5; CpuSize = 2'd3; CpuReq = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 10 && n == 0; cyc++) begin
            @(posedge Clk); #1;
            if (CpuGnt) n = 1;
        end
        CpuReq = 1'b0;
        checkOutput("rst.gnt_seen", n, 32'd1);
        @(posedge Clk); #1;
        checkOutput("rst.capture_rim", {30'd0, MemRIM}, 32'd0);
        Rst = 1'b1;
        #1 checkAllZero("rst.async");
        #2 Rst = 1'b0;
        cpu_model = '0;
        dbg_model = '0;
        valid_n = 0;
        err_n = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge Clk); #1;
            if (CpuValid) valid_n++;
            if (Err) err_n++;
        end
        checkOutput("rst.no_valid", valid_n, 32'd0);
        checkOutput("rst.no_err", err_n, 32'd0);
        applyStimulus('{WHO_CPU, 32'h0000_0005, 32'h0, 2'd3, 32'h9BB5_67CA, 1'b0}, "rst.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Rst  input  1  reset, asynchronous, active-high.
REQ-003 LdReq, LdAddr[31:0], LdData[31:0], LdSize[1:0]  input  loader write request, address, data, size.
REQ-004 CpuReq, CpuAddr[31:0], CpuSize[1:0]  input  CPU fetch read request, address, size.
REQ-005 DbgReq, DbgAddr[31:0], DbgSize[1:0]  input  debug-client read request, address, size.
REQ-006 MemReadData  input  32  instruction-memory registered read data, valid the cycle after the memory samples RIM.
REQ-007 MemWriteData, MemWriteAddr, MemReadAddr  output  32 each  instruction-memory write data and address, read address.
REQ-008 MemWIM, MemRIM  output  2 each  instruction-memory write/read size codes; 0=idle, 1=byte, 2=halfword, 3=word.
REQ-009 LdGnt, CpuGnt, DbgGnt  output  1 each  one-cycle accept pulse per requester.
REQ-010 LdDone  output  1  one-cycle write-completion pulse.
REQ-011 CpuValid, CpuData[31:0], DbgValid, DbgData[31:0]  output  one-cycle read-response pulse and data.
REQ-012 Err  output  1  one-cycle pulse concurrent with the LdDone/CpuValid/DbgValid of a rejected access.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP; all outputs SHALL be registered.
REQ-014 In IDLE, arbitration SHALL pick LdReq first; otherwise between CpuReq and DbgReq round-robin, preferring the read requester not served last.
REQ-015 On selection at edge k, the block SHALL latch Addr/Data/Size, enter ISSUE, and pulse the matching Gnt in cycle k+1 only.
REQ-016 Requesters SHALL hold Req and operands until Gnt; Req still high after Gnt is a new request.
REQ-017 Byte count SHALL be 1/2/4 for Size 1/2/3; an access SHALL be rejected when Size==0 or Addr+count-1 > 0x0000FFFF (33-bit sum, no wrap).
REQ-018 Write in ISSUE: MemWIM=Size, MemWriteAddr/MemWriteData=latched values for exactly one cycle; next state RESP.
REQ-019 Read in ISSUE: MemRIM=Size, MemReadAddr=latched address for exactly one cycle; next state CAPTURE.
REQ-020 In CAPTURE, MemRIM/MemWIM SHALL be 0 and MemReadData SHALL be latched into the requester's Data register; next state RESP.
REQ-021 Rejected access: ISSUE SHALL drive MemWIM=MemRIM=0, skip CAPTURE, load Data=0, and pulse Err in RESP.
REQ-022 In RESP, exactly one of LdDone/CpuValid/DbgValid SHALL pulse; next state IDLE.
REQ-023 Latency: grant at edge k gives write done in cycle k+2 and read valid in cycle k+3; IDLE SHALL last at least one cycle between transactions.
REQ-024 CpuData/DbgData SHALL hold their last value until the next response to that requester.
REQ-025 Requests arriving outside IDLE SHALL wait; they are never dropped while Req is held.
REQ-026 The round-robin pointer SHALL update only on grant of a read, and loader grants SHALL not change it.

Reset
REQ-027 Rst SHALL force IDLE, all outputs 0, and the round-robin pointer to "CPU preferred", independent of Clk.
REQ-028 Rst during ISSUE/CAPTURE/RESP SHALL abort the transaction with no Done/Valid/Err pulse; memory writes already sampled are not undone.

Verification
REQ-029 Loader write Addr=0x5, Data=0x9BB567CA, Size=3, then CPU read Addr=0x5, Size=3 -> CpuValid once, CpuData=0x9BB567CA, Err=0.
REQ-030 CpuReq and DbgReq both held from reset, reads of 0x0 size 1 -> grants alternate Cpu, Dbg, Cpu, Dbg.
REQ-031 LdReq, CpuReq and DbgReq asserted in the same cycle -> LdGnt first, then CpuGnt, then DbgGnt.
REQ-032 CPU read Addr=0xFFFE, Size=3 -> no MemRIM activity, CpuValid with Err=1 and CpuData=0.
REQ-033 CPU read Addr=0xFFFC, Size=3 -> accepted with Err=0.
REQ-034 Rst pulsed during CAPTURE -> no CpuValid, all outputs 0; a following request completes normally.
